// File: rtl/mrp_rx_msg_writer.sv
// Appends MRP receive payload beats into per-connection message slots of an external
// buffer RAM and emits one completion record per finished message.
module mrp_rx_msg_writer #(
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned PAD_W        = 6,
    parameter int unsigned CONN_ID_W    = 3,
    parameter int unsigned SLOT_LINES_W = 8,
    parameter int unsigned LEN_W        = SLOT_LINES_W + PAD_W + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              meta_val,
    input  logic                              meta_start,
    input  logic                              meta_msg_done,
    input  logic [CONN_ID_W-1:0]              meta_conn_id,
    output logic                              meta_rdy,
    input  logic                              data_val,
    input  logic [DATA_W-1:0]                 data,
    input  logic                              data_last,
    input  logic [PAD_W-1:0]                  data_padbytes,
    output logic                              data_rdy,
    output logic                              wr_val,
    output logic [CONN_ID_W+SLOT_LINES_W-1:0] wr_addr,
    output logic [DATA_W-1:0]                 wr_data,
    input  logic                              wr_rdy,
    output logic                              cmpl_val,
    output logic [CONN_ID_W-1:0]              cmpl_conn_id,
    output logic [LEN_W-1:0]                  cmpl_len,
    output logic                              cmpl_err,
    input  logic                              cmpl_rdy
);

    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned NUM_CONN = 1 << CONN_ID_W;
    localparam int unsigned OFF_W    = SLOT_LINES_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        NOTIFY = 2'd2
    } state_t;

    state_t state;

    // Per-connection message table
    logic [NUM_CONN-1:0] act_q;
    logic [NUM_CONN-1:0] err_q;
    logic [OFF_W-1:0]    off_q [NUM_CONN];
    logic [LEN_W-1:0]    len_q [NUM_CONN];

    logic [CONN_ID_W-1:0] cur_conn;
    logic                 cur_done;

    logic             e_err_c;
    logic [OFF_W-1:0] e_off_c;
    logic [LEN_W-1:0] e_len_c;
    logic             drop_c;
    logic             beat_hs_c;
    logic             wr_hs_c;
    logic [LEN_W-1:0] beat_bytes_c;
    logic             err_nxt_c;
    logic [OFF_W-1:0] off_nxt_c;
    logic [LEN_W-1:0] len_nxt_c;

    // Zero-latency beat passthrough and next table-entry values for the current packet.
    // A padded last beat of a non-final packet breaks the whole-line segmentation rule.
    always_comb begin
        e_err_c      = err_q[cur_conn];
        e_off_c      = off_q[cur_conn];
        e_len_c      = len_q[cur_conn];
        drop_c       = (state == DATA) && (e_err_c || e_off_c[SLOT_LINES_W]);
        wr_val       = (state == DATA) && !drop_c && data_val;
        data_rdy     = (state == DATA) && (drop_c || wr_rdy);
        wr_addr      = {cur_conn, e_off_c[SLOT_LINES_W-1:0]};
        wr_data      = data;
        beat_hs_c    = data_val && data_rdy;
        wr_hs_c      = wr_val && wr_rdy;
        beat_bytes_c = data_last ? (LEN_W'(BYTES) - LEN_W'(data_padbytes)) : LEN_W'(BYTES);
        err_nxt_c    = e_err_c;
        if (beat_hs_c && drop_c) begin
            err_nxt_c = 1'b1;
        end
        if (beat_hs_c && data_last && !cur_done && (data_padbytes != '0)) begin
            err_nxt_c = 1'b1;
        end
        off_nxt_c = wr_hs_c ? (e_off_c + OFF_W'(1)) : e_off_c;
        len_nxt_c = wr_hs_c ? (e_len_c + beat_bytes_c) : e_len_c;
    end

    // Packet sequencing FSM, table updates and registered handshake/completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            meta_rdy     <= 1'b0;
            cmpl_val     <= 1'b0;
            cmpl_conn_id <= '0;
            cmpl_len     <= '0;
            cmpl_err     <= 1'b0;
            cur_conn     <= '0;
            cur_done     <= 1'b0;
            act_q        <= '0;
            err_q        <= '0;
            for (int i = 0; i < int'(NUM_CONN); i++) begin
                off_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (meta_val && meta_rdy) begin
                        cur_conn <= meta_conn_id;
                        cur_done <= meta_msg_done;
                        meta_rdy <= 1'b0;
                        state    <= DATA;
                        if (meta_start) begin
                            act_q[meta_conn_id] <= 1'b1;
                            err_q[meta_conn_id] <= 1'b0;
                            off_q[meta_conn_id] <= '0;
                            len_q[meta_conn_id] <= '0;
                        end else if (!act_q[meta_conn_id]) begin
                            err_q[meta_conn_id] <= 1'b1;
                        end
                    end else begin
                        meta_rdy <= 1'b1;
                    end
                end
                DATA: begin
                    if (beat_hs_c) begin
                        err_q[cur_conn] <= err_nxt_c;
                        off_q[cur_conn] <= off_nxt_c;
                        len_q[cur_conn] <= len_nxt_c;
                        if (data_last) begin
                            if (cur_done) begin
                                state        <= NOTIFY;
                                cmpl_val     <= 1'b1;
                                cmpl_conn_id <= cur_conn;
                                cmpl_len     <= len_nxt_c;
                                cmpl_err     <= err_nxt_c;
                            end else begin
                                state    <= IDLE;
                                meta_rdy <= 1'b1;
                            end
                        end
                    end
                end
                NOTIFY: begin
                    if (cmpl_rdy) begin
                        cmpl_val        <= 1'b0;
                        act_q[cur_conn] <= 1'b0;
                        state           <= IDLE;
                        meta_rdy        <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
